staggered_addsub_pipe: RTL

//  Parametrised staggered (chunk-serial carry) pipelined adder/subtractor with valid/ready

---
 rtl/staggered_addsub_pipe_if.sv | 27 ++
 rtl/staggered_addsub_pipe.sv | 128 ++++++++++++
 2 files changed

// File: rtl/staggered_addsub_pipe_if.sv
// Operand/result handshake bundle for staggered_addsub_pipe.
// master: operand producer + result consumer side; slave: the pipeline itself.
interface staggered_addsub_pipe_if #(
    parameter int unsigned N = 16
) ();
    logic         in_valid;
    logic         in_ready;
    logic [N-1:0] a_in;
    logic [N-1:0] b_in;
    logic         c_in;
    logic         sub_in;
    logic         out_valid;
    logic         out_ready;
    logic [N-1:0] s_out;
    logic         c_out;
    logic         ovf_out;

    modport master (
        output in_valid, a_in, b_in, c_in, sub_in, out_ready,
        input  in_ready, out_valid, s_out, c_out, ovf_out
    );

    modport slave (
        input  in_valid, a_in, b_in, c_in, sub_in, out_ready,
        output in_ready, out_valid, s_out, c_out, ovf_out
    );
endinterface

// File: rtl/staggered_addsub_pipe.sv
// Staggered (chunk-serial carry) pipelined adder/subtractor with valid/ready flow control.
// S0 registers the operands (B pre-inverted for subtract), S1..SK each resolve one
// CHUNK-bit slice LSB first, and a final register presents sum, carry and signed overflow.
// The whole pipeline advances together whenever the output register is empty or drained.
module staggered_addsub_pipe #(
    parameter int unsigned N     = 16,
    parameter int unsigned CHUNK = 8
) (
    input logic                  clk,
    input logic                  rst,
    staggered_addsub_pipe_if.slave bus
);
    localparam int unsigned K = N / CHUNK;

    if (CHUNK == 0 || N == 0 || (N % CHUNK) != 0) begin : g_bad_width
        $fatal(1, "staggered_addsub_pipe: N must be a nonzero multiple of CHUNK");
    end

    logic               adv;

    logic               vld_q   [0:K];
    logic               vld_d   [0:K];
    logic [N-1:0]       a_q     [0:K];
    logic [N-1:0]       a_d     [0:K];
    logic [N-1:0]       b_q     [0:K];
    logic [N-1:0]       b_d     [0:K];
    logic [N-1:0]       sum_q   [0:K];
    logic [N-1:0]       sum_d   [0:K];
    logic               cy_q    [0:K];
    logic               cy_d    [0:K];

    logic [CHUNK:0]     slice_sum [1:K];

    logic               out_valid_q, out_valid_d;
    logic [N-1:0]       s_out_q, s_out_d;
    logic               c_out_q, c_out_d;
    logic               ovf_q, ovf_d;

    // Per-stage slice adder: stage i resolves slice i-1 using the carry handed down from stage i-1.
    always_comb begin
        for (int unsigned i = 1; i <= K; i++) begin
            slice_sum[i] = {1'b0, a_q[i-1][(i-1)*CHUNK +: CHUNK]}
                         + {1'b0, b_q[i-1][(i-1)*CHUNK +: CHUNK]}
                         + {{CHUNK{1'b0}}, cy_q[i-1]};
        end
    end

    // Next-state: shift every stage one place on advance, hold everything otherwise.
    // Data is only captured behind a valid bit so outputs never pick up undriven operands.
    always_comb begin
        adv = !out_valid_q || bus.out_ready;

        for (int unsigned i = 0; i <= K; i++) begin
            vld_d[i] = vld_q[i];
            a_d[i]   = a_q[i];
            b_d[i]   = b_q[i];
            sum_d[i] = sum_q[i];
            cy_d[i]  = cy_q[i];
        end
        out_valid_d = out_valid_q;
        s_out_d     = s_out_q;
        c_out_d     = c_out_q;
        ovf_d       = ovf_q;

        if (adv) begin
            vld_d[0] = bus.in_valid;
            if (bus.in_valid) begin
                a_d[0]   = bus.a_in;
                b_d[0]   = bus.sub_in ? ~bus.b_in : bus.b_in;
                cy_d[0]  = bus.c_in ^ bus.sub_in;
                sum_d[0] = '0;
            end

            for (int unsigned i = 1; i <= K; i++) begin
                vld_d[i] = vld_q[i-1];
                if (vld_q[i-1]) begin
                    a_d[i]   = a_q[i-1];
                    b_d[i]   = b_q[i-1];
                    cy_d[i]  = slice_sum[i][CHUNK];
                    sum_d[i] = sum_q[i-1];
                    sum_d[i][(i-1)*CHUNK +: CHUNK] = slice_sum[i][CHUNK-1:0];
                end
            end

            out_valid_d = vld_q[K];
            if (vld_q[K]) begin
                s_out_d = sum_q[K];
                c_out_d = cy_q[K];
                ovf_d   = (a_q[K][N-1] == b_q[K][N-1]) && (sum_q[K][N-1] != a_q[K][N-1]);
            end
        end
    end

    // State registers with synchronous active-low reset flushing all in-flight operands.
    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int unsigned i = 0; i <= K; i++) begin
                vld_q[i] <= 1'b0;
                a_q[i]   <= '0;
                b_q[i]   <= '0;
                sum_q[i] <= '0;
                cy_q[i]  <= 1'b0;
            end
            out_valid_q <= 1'b0;
            s_out_q     <= '0;
            c_out_q     <= 1'b0;
            ovf_q       <= 1'b0;
        end else begin
            for (int unsigned i = 0; i <= K; i++) begin
                vld_q[i] <= vld_d[i];
                a_q[i]   <= a_d[i];
                b_q[i]   <= b_d[i];
                sum_q[i] <= sum_d[i];
                cy_q[i]  <= cy_d[i];
            end
            out_valid_q <= out_valid_d;
            s_out_q     <= s_out_d;
            c_out_q     <= c_out_d;
            ovf_q       <= ovf_d;
        end
    end

    assign bus.in_ready  = adv && rst;
    assign bus.out_valid = out_valid_q;
    assign bus.s_out     = s_out_q;
    assign bus.c_out     = c_out_q;
    assign bus.ovf_out   = ovf_q;
endmodule
